// File: rtl/pitch_pkg.sv
// Shared types and helpers for the pitch angle stages.
package pitch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INTEG,
        ST_BLEND,
        ST_OUT
    } pitch_state_e;

    localparam int PITCH_FRAC_BITS = 7;
    localparam int DEG180_Q7       = 23040;
    localparam int DEG360_Q7       = 46080;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7fff;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/sat_wrap16.sv
// Saturates an 18-bit signed angle to 16 bits; with PITCH_CF_WRAP_EN defined the
// saturated value is then wrapped into +/-180 degrees (Q9.7).
module sat_wrap16
    import pitch_pkg::*;
(
    input  logic signed [17:0] din,
    output logic signed [15:0] dout
);

    logic signed [15:0] sat;
`ifdef PITCH_CF_WRAP_EN
    logic signed [17:0] sat_ext;
`endif

    always_comb begin
        sat  = sat16(din);
`ifdef PITCH_CF_WRAP_EN
        sat_ext = 18'(sat);
        if (sat_ext > 18'(DEG180_Q7))
            dout = 16'(sat_ext - 18'(DEG360_Q7));
        else if (sat_ext < -18'(DEG180_Q7))
            dout = 16'(sat_ext + 18'(DEG360_Q7));
        else
            dout = sat;
`else
        dout = sat;
`endif
    end

endmodule

// File: rtl/pitch_comp_filter.sv
// Complementary filter fusing accelerometer pitch with integrated gyro rate.
// Optional +/-180 degree wrap of the result is enabled by defining PITCH_CF_WRAP_EN.
module pitch_comp_filter
    import pitch_pkg::*;
#(
    parameter int ALPHA_Q15      = 32113,
    parameter int GYRO_SCALE_Q16 = 1311
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic signed [15:0] pitch_acc,
    input  logic signed [15:0] gyro_rate,
    output logic signed [15:0] pitch_out,
    output logic               pitch_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic signed [31:0] GYRO_SCALE = 32'(GYRO_SCALE_Q16);
    localparam logic signed [39:0] W_GYRO     = 40'(ALPHA_Q15);
    localparam logic signed [39:0] W_ACC      = 40'(32768 - ALPHA_Q15);

    pitch_state_e       state;
    logic               seeded;
    logic signed [15:0] acc_reg;
    logic signed [15:0] gyro_reg;
    logic signed [17:0] pred_reg;
    logic signed [15:0] res_reg;

    logic signed [31:0] gyro_prod;
    logic signed [17:0] pred_next;
    logic signed [17:0] blend_q;
    logic signed [17:0] sw_in;
    logic signed [15:0] sw_out;

    always_comb begin
        gyro_prod = 32'(gyro_reg) * GYRO_SCALE;
        pred_next = 18'(32'(pitch_out) + (gyro_prod >>> 16));
        blend_q   = 18'((W_GYRO * 40'(pred_reg) + W_ACC * 40'(acc_reg) + 40'sd16384) >>> 15);
        // Until the first result exists there is no valid history to blend with.
        sw_in     = seeded ? blend_q : 18'(acc_reg);
    end

    sat_wrap16 u_sat_wrap (
        .din  (sw_in),
        .dout (sw_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            seeded      <= 1'b0;
            acc_reg     <= '0;
            gyro_reg    <= '0;
            pred_reg    <= '0;
            res_reg     <= '0;
            pitch_out   <= '0;
            pitch_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pitch_valid <= 1'b0;
            overrun     <= sample_valid && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        acc_reg  <= pitch_acc;
                        gyro_reg <= gyro_rate;
                        busy     <= 1'b1;
                        state    <= ST_INTEG;
                    end
                end
                ST_INTEG: begin
                    pred_reg <= pred_next;
                    state    <= ST_BLEND;
                end
                ST_BLEND: begin
                    res_reg <= sw_out;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    pitch_out   <= res_reg;
                    pitch_valid <= 1'b1;
                    seeded      <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_comp_filter.sv
// Bench for pitch_comp_filter: default-parameter and pure-integration instances share stimulus.
module tb_pitch_comp_filter;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] pitch_acc = '0;
    logic signed [15:0] gyro_rate = '0;

    logic signed [15:0] d_out, i_out;
    logic               d_valid, i_valid, d_busy, i_busy, d_ovr, i_ovr;

    int vectors = 0;
    int miscompares = 0;

    int m_def = 0;
    int m_int = 0;
    bit m_seeded = 1'b0;

    always #5 clk = ~clk;

    pitch_comp_filter u_def (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .pitch_acc    (pitch_acc),
        .gyro_rate    (gyro_rate),
        .pitch_out    (d_out),
        .pitch_valid  (d_valid),
        .busy         (d_busy),
        .overrun      (d_ovr)
    );

    pitch_comp_filter #(
        .ALPHA_Q15      (32768),
        .GYRO_SCALE_Q16 (65536)
    ) u_int (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .pitch_acc    (pitch_acc),
        .gyro_rate    (gyro_rate),
        .pitch_out    (i_out),
        .pitch_valid  (i_valid),
        .busy         (i_busy),
        .overrun      (i_ovr)
    );

    function automatic longint floordiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0))
            q = q - 1;
        return q;
    endfunction

    // Filter behaviour from the arithmetic definition: weighted average, round half up, clamp, wrap.
    function automatic int model(input int prev, input bit seeded, input int acc, input int gyro,
                                 input longint alpha, input longint scale);
        longint r, pred, sum;
        if (!seeded) begin
            r = acc;
        end else begin
            pred = prev + floordiv(longint'(gyro) * scale, 65536);
            sum  = alpha * pred + (32768 - alpha) * acc + 16384;
            r    = floordiv(sum, 32768);
        end
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`ifdef PITCH_CF_WRAP_EN
        if (r > 23040)       r = r - 46080;
        else if (r < -23040) r = r + 46080;
`endif
        return int'(r);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " d_valid"}, 32'(d_valid), 0);
        chk({tag, " i_valid"}, 32'(i_valid), 0);
        chk({tag, " d_busy"}, 32'(d_busy), 0);
        chk({tag, " d_ovr"}, 32'(d_ovr), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst pitch_out", 32'(d_out), 0);
        chk("rst i_out", 32'(i_out), 0);
        chk_idle("rst");
        rst_n = 1'b1;
        m_def = 0;
        m_int = 0;
        m_seeded = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where pitch_valid is expected high.
    task automatic send(input int acc, input int gyro);
        int e_def, e_int;
        e_def = model(m_def, m_seeded, acc, gyro, 32113, 1311);
        e_int = model(m_int, m_seeded, acc, gyro, 32768, 65536);
        sample_valid = 1'b1;
        pitch_acc = 16'(acc);
        gyro_rate = 16'(gyro);
        @(posedge clk);
        #1 sample_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("busy", 32'(d_busy), 1);
            chk("valid early", 32'(d_valid), 0);
        end
        @(negedge clk);
        chk("d_valid", 32'(d_valid), 1);
        chk("i_valid", 32'(i_valid), 1);
        chk("busy done", 32'(d_busy), 0);
        chk("ovr", 32'(d_ovr), 0);
        chk("d_out", 32'(d_out), 32'(e_def));
        chk("i_out", 32'(i_out), 32'(e_int));
        m_def = e_def;
        m_int = e_int;
        m_seeded = 1'b1;
    endtask

    function automatic int rnd16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    initial begin
        int e_def, e_int, expect_wrap;

        // Reset and quiet idle
        @(negedge clk);
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_idle("idle");
        end

        // Seed, then steady input holds
        send(3840, 500);
        chk("seed value", 32'(d_out), 3840);
        send(3840, 0);
        chk("steady", 32'(d_out), 3840);

        // Reset mid-computation discards the sample
        sample_valid = 1'b1;
        pitch_acc = 16'sd1000;
        gyro_rate = 16'sd0;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", 32'(d_busy), 0);
        chk("midrst out", 32'(d_out), 0);
        rst_n = 1'b1;
        m_def = 0;
        m_int = 0;
        m_seeded = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_idle("post midrst");
        end

        // Step response after seeding 0 (also checks seeded was cleared)
        send(0, 0);
        send(12800, 0);
        chk("step", 32'(d_out), 256);

        // Pure integration on u_int
        do_reset();
        send(0, 0);
        for (int k = 1; k <= 10; k++) begin
            send(rnd16(), 100);
            chk("integ", 32'(i_out), 32'(k * 100));
        end

        // Overrun: second strobe one cycle later is dropped
        e_def = model(m_def, m_seeded, 2000, 50, 32113, 1311);
        e_int = model(m_int, m_seeded, 2000, 50, 32768, 65536);
        sample_valid = 1'b1;
        pitch_acc = 16'sd2000;
        gyro_rate = 16'sd50;
        @(posedge clk);
        #1;
        pitch_acc = -16'sd9000;
        gyro_rate = -16'sd3000;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(negedge clk);
        chk("ovr pulse", 32'(d_ovr), 1);
        chk("ovr pulse int", 32'(i_ovr), 1);
        @(negedge clk);
        chk("ovr once", 32'(d_ovr), 0);
        @(negedge clk);
        chk("ovr valid", 32'(d_valid), 1);
        chk("ovr d_out", 32'(d_out), 32'(e_def));
        chk("ovr i_out", 32'(i_out), 32'(e_int));
        m_def = e_def;
        m_int = e_int;
        // Strobe coincident with pitch_valid is accepted
        send(-1500, 20);

        // Wrap / saturation boundaries on u_int
        do_reset();
        send(23000, 0);
        send(rnd16(), 100);
`ifdef PITCH_CF_WRAP_EN
        expect_wrap = -22980;
`else
        expect_wrap = 23100;
`endif
        chk("wrap", 32'(i_out), 32'(expect_wrap));
        do_reset();
        send(32700, 0);
        send(rnd16(), 200);
`ifdef PITCH_CF_WRAP_EN
        expect_wrap = 32767 - 46080;
`else
        expect_wrap = 32767;
`endif
        chk("sat", 32'(i_out), 32'(expect_wrap));

        // Randomized sweep
        do_reset();
        for (int n = 0; n < 30; n++)
            send(rnd16(), rnd16());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
